// File: rtl/bin_to_bcd_encoder_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the per-digit add-3 adjustment.
package bin_to_bcd_encoder_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // Digits >= 5 would carry past 9 after the next doubling, so pre-bias them.
    function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational add-3 correction for one BCD digit ahead of the shift.
module bcd_digit_adjust
    import bin_to_bcd_encoder_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = bcd_add3(i_digit);

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Result and overflow are registered and held until the next conversion completes.
module bin_to_bcd_encoder
    import bin_to_bcd_encoder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);

    state_e                r_state;
    logic [WIDTH-1:0]      r_sr;
    logic [4*DIGITS-1:0]   r_acc;
    logic                  r_sticky;
    logic [CntW-1:0]       r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_acc_next;
    logic                  w_carry;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_acc[4*i +: 4]),
            .o_digit (w_adj[4*i +: 4])
        );
    end

    // The bit leaving the top digit is a carry past 10^DIGITS.
    assign w_carry    = w_adj[4*DIGITS-1];
    assign w_acc_next = {w_adj[4*DIGITS-2:0], r_sr[WIDTH-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_sr     <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_sr     <= bin;
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                        r_cnt    <= CntLoad;
                        r_busy   <= 1'b1;
                        r_state  <= StShift;
                    end
                end
                StShift: begin
                    r_sr     <= r_sr << 1;
                    r_acc    <= w_acc_next;
                    r_sticky <= r_sticky | w_carry;
                    r_cnt    <= r_cnt - CntOne;
                    if (r_cnt == CntOne) begin
                        r_bcd   <= w_acc_next;
                        r_ovf   <= r_sticky | w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Directed-vector bench for bin_to_bcd_encoder in a 16-bit/5-digit and an 8-bit/2-digit build.
module tb_bin_to_bcd_encoder;

    localparam int AW = 16;
    localparam int AD = 5;
    localparam int BW = 8;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_start, b_start;
    logic [AW-1:0] a_bin;
    logic [BW-1:0] b_bin;
    logic          a_busy, a_done, a_ovf;
    logic          b_busy, b_done, b_ovf;
    logic [4*AD-1:0] a_bcd;
    logic [4*BD-1:0] b_bcd;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] a_last = '0;
    logic [19:0] b_last = '0;

    always #5 clk = ~clk;

    bin_to_bcd_encoder #(.WIDTH(AW), .DIGITS(AD)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (a_start),
        .bin      (a_bin),
        .busy     (a_busy),
        .done     (a_done),
        .bcd      (a_bcd),
        .overflow (a_ovf)
    );

    bin_to_bcd_encoder #(.WIDTH(BW), .DIGITS(BD)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .bin      (b_bin),
        .busy     (b_busy),
        .done     (b_done),
        .bcd      (b_bcd),
        .overflow (b_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v, input int digits);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic drive(input int which, input logic st, input int unsigned v);
        if (which == 0) begin
            a_start = st;
            a_bin   = AW'(v);
        end else begin
            b_start = st;
            b_bin   = BW'(v);
        end
    endtask

    function automatic logic [31:0] cur_bcd(input int which);
        return (which == 0) ? 32'(a_bcd) : 32'(b_bcd);
    endfunction

    task automatic wait_done(input int which, input int hold_at, input logic [19:0] hold_bcd,
                             input string tag, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == hold_at) check_val({tag, "_hold"}, cur_bcd(which), 32'(hold_bcd));
            if ((which == 0) ? a_done : b_done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic convert(input int which, input int unsigned v, input logic [19:0] exp_bcd,
                           input logic exp_ovf, input string tag);
        int w;
        int cyc;
        logic [19:0] prev;
        w    = (which == 0) ? AW : BW;
        prev = (which == 0) ? a_last : b_last;
        @(negedge clk);
        drive(which, 1'b1, v);
        @(posedge clk);
        #1;
        // Scramble bin after acceptance; it must not affect the result.
        drive(which, 1'b0, ~v);
        check_val({tag, "_busy"}, 32'((which == 0) ? a_busy : b_busy), 32'd1);
        wait_done(which, w / 2, prev, tag, cyc);
        check_val({tag, "_cyc"}, 32'(cyc), 32'(w));
        check_val({tag, "_bcd"}, cur_bcd(which), 32'(exp_bcd));
        check_val({tag, "_ovf"}, 32'((which == 0) ? a_ovf : b_ovf), 32'(exp_ovf));
        check_val({tag, "_idle"}, 32'((which == 0) ? a_busy : b_busy), 32'd0);
        if (which == 0) a_last = exp_bcd;
        else            b_last = exp_bcd;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int seen;
        int bad;
        int unsigned v;

        rst = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        a_bin = '0;
        b_bin = '0;
        #12;
        check_val("rst_busy", 32'(a_busy), 32'd0);
        check_val("rst_done", 32'(a_done), 32'd0);
        check_val("rst_bcd", 32'(a_bcd), 32'd0);
        check_val("rst_ovf", 32'(a_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        convert(0, 0, 20'h00000, 1'b0, "a_zero");
        convert(0, 1234, 20'h01234, 1'b0, "a_1234");
        convert(0, 65535, 20'h65535, 1'b0, "a_65535");
        convert(1, 255, 20'h00055, 1'b1, "b_255");
        convert(1, 99, 20'h00099, 1'b0, "b_99");
        convert(1, 100, 20'h00000, 1'b1, "b_100");

        // Start held through the conversion with bin changing, then back-to-back on done.
        @(negedge clk);
        a_start = 1'b1;
        a_bin   = 16'd42;
        @(posedge clk);
        #1;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) a_bin = 16'd777;
            if (a_done) begin
                cyc = k;
                break;
            end
        end
        check_val("b2b_cyc1", 32'(cyc), 32'd16);
        check_val("b2b_bcd1", 32'(a_bcd), 32'h00042);
        a_bin = 16'd9;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        check_val("b2b_busy2", 32'(a_busy), 32'd1);
        check_val("b2b_done_pulse", 32'(a_done), 32'd0);
        wait_done(0, 8, 20'h00042, "b2b2", cyc);
        check_val("b2b_cyc2", 32'(cyc), 32'd16);
        check_val("b2b_bcd2", 32'(a_bcd), 32'h00009);
        a_last = 20'h00009;

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        a_start = 1'b1;
        a_bin   = 16'd1234;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(a_busy), 32'd0);
        check_val("arst_done", 32'(a_done), 32'd0);
        check_val("arst_bcd", 32'(a_bcd), 32'd0);
        check_val("arst_ovf", 32'(a_ovf), 32'd0);
        a_last = '0;
        b_last = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (a_done) seen++;
        end
        check_val("arst_no_done", 32'(seen), 32'd0);
        convert(0, 4321, 20'h04321, 1'b0, "a_after_rst");

        bad = 0;
        for (int n = 0; n < 100; n++) begin
            v = $urandom_range(0, 65535);
            convert(0, v, ref_bcd(v, AD), 1'b0, "a_rand");
            for (int d = 0; d < AD; d++) if (a_bcd[4*d +: 4] > 4'd9) bad++;
        end
        for (int n = 0; n < 100; n++) begin
            v = $urandom_range(0, 255);
            convert(1, v, ref_bcd(v, BD), (v > 99), "b_rand");
            for (int d = 0; d < BD; d++) if (b_bcd[4*d +: 4] > 4'd9) bad++;
        end
        check_val("digit_range", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
